// File: rtl/pipes_scroller.sv
// pipes_scroller: per-frame update engine that sits upstream of pipes_list.
// On each frame_tick it sweeps the list once, moving every pipe left by SPEED,
// removing pipes that have left the screen and pulsing score_pulse when a pipe
// crosses BIRD_X. After the sweep it spawns a new pipe at the right edge every
// SPAWN_PERIOD frames, using an LFSR for the gap height.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ce            clock enable; ce=0 freezes all state and registered outputs
//   frame_tick    one-cycle pulse that starts a frame update
//   busy          high while the engine is not idle
//   overrun       sticky: frame_tick arrived while busy (cleared by rst only)
//   score_pulse   one-cycle pulse per pipe passing BIRD_X
//   count         current pipes_list element count
//   insert_en     insert strobe to pipes_list (one cycle)
//   insert_data   pipe to insert
//   iter_start    starts a list sweep (one cycle)
//   iter_done     list sweep complete
//   iter_out      current element presented by the list
//   iter_in       updated element written back to the list
//   iter_remove   delete the current element

package pipes_pkg;
  typedef struct packed {
    logic signed [10:0] x;
    logic [9:0]         gap_y;
    logic [2:0]         kind;
  } pipe_t;
endpackage

module pipes_scroller
  import pipes_pkg::*;
#(
  parameter int SPEED        = 2,
  parameter int SCREEN_W     = 640,
  parameter int PIPE_W       = 64,
  parameter int BIRD_X       = 160,
  parameter int SPAWN_PERIOD = 90,
  parameter int GAP_MIN      = 100,
  parameter int MAX_PIPES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       frame_tick,
  output logic       busy,
  output logic       overrun,
  output logic       score_pulse,
  input  logic [4:0] count,
  output logic       insert_en,
  output pipe_t      insert_data,
  output logic       iter_start,
  input  logic       iter_done,
  input  pipe_t      iter_out,
  output pipe_t      iter_in,
  output logic       iter_remove
);

  localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
  localparam logic [CNT_W-1:0]   RELOAD     = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic signed [10:0] SPEED_S    = 11'(SPEED);
  localparam logic signed [10:0] REMOVE_LIM = 11'(-PIPE_W);
  localparam logic signed [10:0] BIRD_S     = 11'(BIRD_X);
  localparam logic signed [10:0] SPAWN_X    = 11'(SCREEN_W);
  localparam logic [9:0]         GAP_BASE   = 10'(GAP_MIN);
  localparam logic [5:0]         MAX_CNT    = 6'(MAX_PIPES);

  typedef enum logic [1:0] {IDLE, START, ITER, SPAWN} state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             score_q, score_d;
  logic             insert_en_q, insert_en_d;
  pipe_t            insert_data_q, insert_data_d;
  logic             iter_start_q, iter_start_d;
  logic [CNT_W-1:0] spawn_cnt_q, spawn_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;

  logic signed [10:0] x_cur;
  logic signed [10:0] new_x;
  logic               sweeping;

  // Write-back path is combinational so the list can update the element in the
  // same cycle it presents it; it is forced to zero outside an active sweep.
  always_comb begin
    x_cur       = iter_out.x;
    new_x       = x_cur - SPEED_S;
    sweeping    = (state_q == ITER) && !iter_done;
    iter_in     = '0;
    iter_remove = 1'b0;
    if (sweeping) begin
      iter_in     = iter_out;
      iter_in.x   = new_x;
      iter_remove = (new_x < REMOVE_LIM);
    end
  end

  always_comb begin
    // Galois LFSR, shift right, taps 16'hB400; free-running while ce=1.
    lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    state_d       = state_q;
    busy_d        = busy_q;
    iter_start_d  = 1'b0;
    insert_en_d   = 1'b0;
    insert_data_d = insert_data_q;
    spawn_cnt_d   = spawn_cnt_q;
    // Crossing test uses the unmodified x so a pipe scores exactly once.
    score_d       = sweeping && (x_cur >= BIRD_S) && (new_x < BIRD_S);
    // A tick outside IDLE is dropped, only flagged.
    overrun_d     = overrun_q | (frame_tick && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d      = START;
          busy_d       = 1'b1;
          iter_start_d = 1'b1;
        end
      end
      START: state_d = ITER;
      ITER: begin
        if (iter_done) state_d = SPAWN;
      end
      SPAWN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (spawn_cnt_q == '0) begin
          // The counter reloads even when the list is full, so a blocked
          // spawn is skipped rather than retried next frame.
          spawn_cnt_d = RELOAD;
          if ({1'b0, count} < MAX_CNT) begin
            insert_en_d         = 1'b1;
            insert_data_d       = '0;
            insert_data_d.x     = SPAWN_X;
            insert_data_d.gap_y = GAP_BASE + 10'(lfsr_q[6:0]);
          end
        end else begin
          spawn_cnt_d = spawn_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      score_q       <= 1'b0;
      insert_en_q   <= 1'b0;
      insert_data_q <= '0;
      iter_start_q  <= 1'b0;
      spawn_cnt_q   <= '0;
      lfsr_q        <= 16'hACE1;
    end else if (ce) begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      score_q       <= score_d;
      insert_en_q   <= insert_en_d;
      insert_data_q <= insert_data_d;
      iter_start_q  <= iter_start_d;
      spawn_cnt_q   <= spawn_cnt_d;
      lfsr_q        <= lfsr_d;
    end
  end

  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign score_pulse = score_q;
  assign insert_en   = insert_en_q;
  assign insert_data = insert_data_q;
  assign iter_start  = iter_start_q;

endmodule
